// File: rtl/bp_pkg.sv
// Shared types, encodings and helpers for the dynamic branch predictor.
// BTB tag/target fields are sized for the widest supported address (64 bits);
// narrower configurations zero-extend into them, and synthesis prunes the
// constant upper bits.
package bp_pkg;

  // funct3 encodings of the conditional branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // opcode[6:5] shared by BRANCH, JAL and JALR
  localparam logic [1:0] OP_CLASS_BRJ = 2'b11;

  // widest address the BTB fields can hold
  localparam int BTB_W_MAX = 64;

  // 2-bit direction counter states
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_t;

  // BHT write-port command; the table applies it as a read-modify-write
  typedef enum logic [1:0] {
    BHT_HOLD   = 2'b00,
    BHT_INC    = 2'b01,
    BHT_DEC    = 2'b10,
    BHT_SET_ST = 2'b11
  } bht_op_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_W_MAX-1:0] tag;
    logic [BTB_W_MAX-1:0] target;
    logic                 isJump;
  } btb_entry_t;

  // Direction of a conditional branch from funct3 and the ALU zero flag.
  // The ALU computes SUB for BEQ/BNE and SLT/SLTU for the ordered compares,
  // so "less than" shows up as a non-zero result.
  function automatic logic branchCond(input logic [2:0] funct3, input logic zero);
    logic cond;
    case (funct3)
      F3_BEQ, F3_BGE, F3_BGEU: cond = zero;
      F3_BNE, F3_BLT, F3_BLTU: cond = ~zero;
      default:                 cond = 1'b0;
    endcase
    return cond;
  endfunction

  // Saturating 2-bit counter step
  function automatic logic [1:0] bhtNext(input logic [1:0] ctr, input bht_op_t op);
    logic [1:0] nxt;
    nxt = ctr;
    case (op)
      BHT_INC:    if (ctr != ST)  nxt = ctr + 2'd1;
      BHT_DEC:    if (ctr != SNT) nxt = ctr - 2'd1;
      BHT_SET_ST: nxt = ST;
      default:    nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_table.sv
// BHT counters and direct-mapped BTB, one combinational read port for Fetch
// and one synchronous write port for Execute. Reads see pre-edge contents;
// there is deliberately no write-to-read bypass.
module bp_table
  import bp_pkg::*;
#(
  parameter int         ENTRIES    = 64,
  parameter logic [1:0] INIT_STATE = 2'b01,
  localparam int        IDX_W      = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [1:0]       rdCtr,
  output btb_entry_t       rdEntry,
  input  logic [IDX_W-1:0] wrIdx,
  input  bht_op_t          bhtOp,
  input  logic             btbWe,
  input  btb_entry_t       btbWrData
);

  logic [1:0] bht [ENTRIES];
  btb_entry_t btb [ENTRIES];

  // Fetch lookup
  always_comb begin
    rdCtr   = bht[rdIdx];
    rdEntry = btb[rdIdx];
  end

  // BHT update; reset returns every counter to the configured initial state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= INIT_STATE;
    end else if (bhtOp != BHT_HOLD) begin
      bht[wrIdx] <= bhtNext(bht[wrIdx], bhtOp);
    end
  end

  // BTB allocate/refresh; reset invalidates every entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (btbWe) begin
      btb[wrIdx] <= btbWrData;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage direction/target prediction plus Execute-stage resolution,
// table update policy and saturating performance counters.
// XLEN must not exceed bp_pkg::BTB_W_MAX.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] INIT_STATE  = 2'b01,
  parameter int         CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            ValidE,
  input  logic            StallE,
  input  logic [1:0]      opE_65,
  input  logic [2:0]      funct3E,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            ZeroE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] PCRedirectE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredictCount
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0] idxF, idxE;
  logic [TAG_W-1:0] tagF, tagE;
  logic [1:0]       rdCtr;
  btb_entry_t       rdEntry;
  logic             hitF;
  logic             resolveE, condE, takenE, updE;
  bht_op_t          bhtOp;
  logic             btbWe;
  btb_entry_t       btbWrData;

  // Instructions are word aligned; the two low PC bits never index or tag.
  logic unusedPcBits;
  assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

  assign idxF = PCF[IDX_W+1:2];
  assign tagF = PCF[XLEN-1:IDX_W+2];
  assign idxE = PCE[IDX_W+1:2];
  assign tagE = PCE[XLEN-1:IDX_W+2];

  bp_table #(
    .ENTRIES    (BHT_ENTRIES),
    .INIT_STATE (INIT_STATE)
  ) uTable (
    .clk       (clk),
    .reset_n   (reset_n),
    .rdIdx     (idxF),
    .rdCtr     (rdCtr),
    .rdEntry   (rdEntry),
    .wrIdx     (idxE),
    .bhtOp     (bhtOp),
    .btbWe     (btbWe),
    .btbWrData (btbWrData)
  );

  // Fetch prediction: jumps always redirect on a hit, branches follow the counter MSB
  always_comb begin
    hitF        = rdEntry.valid && (rdEntry.tag == BTB_W_MAX'(tagF));
    PredTakenF  = hitF && (rdEntry.isJump || rdCtr[1]);
    PredTargetF = hitF ? XLEN'(rdEntry.target) : '0;
  end

  // Execute resolution: actual direction, mispredict and the corrected next PC
  always_comb begin
    resolveE    = ValidE && (opE_65 == OP_CLASS_BRJ) && (BranchE || JumpE);
    condE       = branchCond(funct3E, ZeroE);
    takenE      = resolveE && (JumpE || (BranchE && condE));
    MispredictE = resolveE &&
                  ((takenE != PredTakenE) ||
                   (takenE && PredTakenE && (PredTargetE != PCTargetE)));
    PCRedirectE = takenE ? PCTargetE : PCPlus4E;
    updE        = resolveE && !StallE;
  end

  // Update policy: BHT always trains, BTB only allocates on taken control flow
  always_comb begin
    bhtOp     = BHT_HOLD;
    btbWe     = 1'b0;
    btbWrData = '{valid:  1'b1,
                  tag:    BTB_W_MAX'(tagE),
                  target: BTB_W_MAX'(PCTargetE),
                  isJump: JumpE};
    if (updE) begin
      if (JumpE)       bhtOp = BHT_SET_ST;
      else if (takenE) bhtOp = BHT_INC;
      else             bhtOp = BHT_DEC;
      btbWe = takenE;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else if (updE) begin
      if (BranchCount != CNT_MAX) BranchCount <= BranchCount + CNT_W'(1);
      if (MispredictE && (MispredictCount != CNT_MAX))
        MispredictCount <= MispredictCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with hand-computed expectations.
// With 64 entries, 0x100 and 0x200 share index 0 (tags 1 and 2).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] PCF = '0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        ValidE = 1'b0, StallE = 1'b0;
  logic [1:0]  opE_65 = '0;
  logic [2:0]  funct3E = '0;
  logic        BranchE = 1'b0, JumpE = 1'b0, ZeroE = 1'b0;
  logic [31:0] PCE = '0, PCPlus4E = '0, PCTargetE = '0;
  logic        PredTakenE = 1'b0;
  logic [31:0] PredTargetE = '0;
  logic        MispredictE;
  logic [31:0] PCRedirectE;
  logic [31:0] BranchCount, MispredictCount;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .PCF             (PCF),
    .PredTakenF      (PredTakenF),
    .PredTargetF     (PredTargetF),
    .ValidE          (ValidE),
    .StallE          (StallE),
    .opE_65          (opE_65),
    .funct3E         (funct3E),
    .BranchE         (BranchE),
    .JumpE           (JumpE),
    .ZeroE           (ZeroE),
    .PCE             (PCE),
    .PCPlus4E        (PCPlus4E),
    .PCTargetE       (PCTargetE),
    .PredTakenE      (PredTakenE),
    .PredTargetE     (PredTargetE),
    .MispredictE     (MispredictE),
    .PCRedirectE     (PCRedirectE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setE(input logic v, input logic s, input logic [1:0] op,
                      input logic [2:0] f3, input logic br, input logic jmp,
                      input logic zero, input logic [31:0] pc, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptg);
    ValidE      = v;
    StallE      = s;
    opE_65      = op;
    funct3E     = f3;
    BranchE     = br;
    JumpE       = jmp;
    ZeroE       = zero;
    PCE         = pc;
    PCPlus4E    = pc + 32'd4;
    PCTargetE   = tgt;
    PredTakenE  = pt;
    PredTargetE = ptg;
  endtask

  task automatic idle();
    ValidE  = 1'b0;
    StallE  = 1'b0;
    BranchE = 1'b0;
    JumpE   = 1'b0;
  endtask

  initial begin
    // reset
    PCF = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_predTaken", PredTakenF, 0);
    chk("rst_predTarget", PredTargetF, 0);
    chk("rst_mispredict", MispredictE, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_predTaken", PredTakenF, 0);
    chk("post_rst_predTarget", PredTargetF, 0);
    chk("post_rst_branchCnt", BranchCount, 0);
    chk("post_rst_mispCnt", MispredictCount, 0);

    // BEQ taken at 0x100, predicted not taken
    setE(1, 0, 2'b11, 3'b000, 1, 0, 1, 32'h100, 32'h140, 0, 32'h0);
    #1;
    chk("beq_misp", MispredictE, 1);
    chk("beq_redirect", PCRedirectE, 32'h140);
    tick(); idle(); #1;
    chk("beq_predTaken_WT", PredTakenF, 1);
    chk("beq_predTarget", PredTargetF, 32'h140);
    chk("beq_branchCnt", BranchCount, 1);
    chk("beq_mispCnt", MispredictCount, 1);

    // correct prediction trains WT -> ST
    setE(1, 0, 2'b11, 3'b000, 1, 0, 1, 32'h100, 32'h140, 1, 32'h140);
    #1;
    chk("beq2_misp", MispredictE, 0);
    tick(); idle(); #1;
    chk("beq2_predTaken_ST", PredTakenF, 1);

    // BNE not taken: ST -> WT
    setE(1, 0, 2'b11, 3'b001, 1, 0, 1, 32'h100, 32'h140, 1, 32'h140);
    #1;
    chk("bne1_misp", MispredictE, 1);
    chk("bne1_redirect", PCRedirectE, 32'h104);
    tick(); idle(); #1;
    chk("bne1_predTaken_WT", PredTakenF, 1);

    // WT -> WNT: prediction flips, entry still hits
    setE(1, 0, 2'b11, 3'b001, 1, 0, 1, 32'h100, 32'h140, 1, 32'h140);
    #1;
    chk("bne2_misp", MispredictE, 1);
    tick(); idle(); #1;
    chk("bne2_predTaken_WNT", PredTakenF, 0);
    chk("bne2_predTarget_hit", PredTargetF, 32'h140);

    // WNT -> SNT, then saturate at SNT
    setE(1, 0, 2'b11, 3'b001, 1, 0, 1, 32'h100, 32'h140, 0, 32'h0);
    #1;
    chk("bne3_misp", MispredictE, 0);
    tick(); idle(); #1;
    chk("bne3_predTaken_SNT", PredTakenF, 0);
    setE(1, 0, 2'b11, 3'b001, 1, 0, 1, 32'h100, 32'h140, 0, 32'h0);
    tick(); idle(); #1;

    // one taken from a saturated SNT lands in WNT (no wrap to ST)
    setE(1, 0, 2'b11, 3'b000, 1, 0, 1, 32'h100, 32'h140, 0, 32'h0);
    tick(); idle(); #1;
    chk("sat_predTaken_WNT", PredTakenF, 0);
    chk("sat_branchCnt", BranchCount, 7);
    chk("sat_mispCnt", MispredictCount, 4);

    // retrain to WT
    setE(1, 0, 2'b11, 3'b000, 1, 0, 1, 32'h100, 32'h140, 0, 32'h0);
    tick(); idle(); #1;
    chk("retrain_predTaken", PredTakenF, 1);

    // alias: same index, different tag
    PCF = 32'h200;
    #1;
    chk("alias_predTaken", PredTakenF, 0);
    chk("alias_predTarget", PredTargetF, 0);
    PCF = 32'h100;

    // stalled resolve: outputs valid, no state change
    setE(1, 1, 2'b11, 3'b000, 1, 0, 0, 32'h100, 32'h140, 1, 32'h140);
    #1;
    chk("stall_misp", MispredictE, 1);
    chk("stall_redirect", PCRedirectE, 32'h104);
    tick(); idle(); #1;
    chk("stall_predTaken", PredTakenF, 1);
    chk("stall_branchCnt", BranchCount, 8);
    chk("stall_mispCnt", MispredictCount, 5);

    // bubble in Execute
    setE(0, 0, 2'b11, 3'b000, 1, 0, 0, 32'h100, 32'h140, 1, 32'h140);
    #1;
    chk("bubble_misp", MispredictE, 0);
    tick(); idle(); #1;
    chk("bubble_predTaken", PredTakenF, 1);
    chk("bubble_branchCnt", BranchCount, 8);

    // wrong opcode class never resolves
    setE(1, 0, 2'b01, 3'b000, 1, 0, 0, 32'h100, 32'h140, 1, 32'h140);
    #1;
    chk("opclass_misp", MispredictE, 0);
    tick(); idle(); #1;
    chk("opclass_branchCnt", BranchCount, 8);

    // JAL at 0x200 with stale target
    PCF = 32'h200;
    setE(1, 0, 2'b11, 3'b000, 0, 1, 0, 32'h200, 32'h304, 1, 32'h300);
    #1;
    chk("jal_misp", MispredictE, 1);
    chk("jal_redirect", PCRedirectE, 32'h304);
    tick(); idle(); #1;
    chk("jal_predTaken", PredTakenF, 1);
    chk("jal_predTarget", PredTargetF, 32'h304);
    chk("jal_branchCnt", BranchCount, 9);
    chk("jal_mispCnt", MispredictCount, 6);
    PCF = 32'h100;
    #1;
    chk("jal_evict_predTaken", PredTakenF, 0);
    chk("jal_evict_predTarget", PredTargetF, 0);

    // funct3 010/011 never taken, no BTB allocation
    PCF = 32'h180;
    setE(1, 0, 2'b11, 3'b010, 1, 0, 1, 32'h180, 32'h1c0, 0, 32'h0);
    #1;
    chk("f010_misp", MispredictE, 0);
    chk("f010_redirect", PCRedirectE, 32'h184);
    tick(); idle(); #1;
    chk("f010_predTaken", PredTakenF, 0);
    chk("f010_predTarget", PredTargetF, 0);
    setE(1, 0, 2'b11, 3'b011, 1, 0, 0, 32'h180, 32'h1c0, 1, 32'h1c0);
    #1;
    chk("f011_misp", MispredictE, 1);
    chk("f011_redirect", PCRedirectE, 32'h184);
    tick(); idle(); #1;

    // BLT taken on non-zero: SNT -> WNT, BTB allocated
    setE(1, 0, 2'b11, 3'b100, 1, 0, 0, 32'h180, 32'h1c0, 0, 32'h0);
    #1;
    chk("blt_misp", MispredictE, 1);
    chk("blt_redirect", PCRedirectE, 32'h1c0);
    tick(); idle(); #1;
    chk("blt_predTaken", PredTakenF, 0);
    chk("blt_predTarget", PredTargetF, 32'h1c0);
    chk("blt_branchCnt", BranchCount, 12);
    chk("blt_mispCnt", MispredictCount, 8);

    // asynchronous reset mid-run clears immediately
    PCF = 32'h200;
    #1;
    chk("pre_rst_predTaken", PredTakenF, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_predTaken", PredTakenF, 0);
    chk("mid_rst_predTarget", PredTargetF, 0);
    chk("mid_rst_branchCnt", BranchCount, 0);
    chk("mid_rst_mispCnt", MispredictCount, 0);
    chk("mid_rst_misp", MispredictE, 0);
    tick();
    reset_n = 1'b1;
    tick();
    PCF = 32'h180;
    #1;
    chk("after_rst_predTaken", PredTakenF, 0);
    chk("after_rst_predTarget", PredTargetF, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
